// File: rtl/program_loader.sv
// Byte-stream loader for the pipelined CPU: parses HDR/CNT/ADDR/word streams into
// IM/DM write strobes and holds the CPU until a RUN header arrives.
module program_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CNT  = 3'd1;
    localparam logic [2:0] S_ADR  = 3'd2;
    localparam logic [2:0] S_HI   = 3'd3;
    localparam logic [2:0] S_LO   = 3'd4;
    localparam logic [2:0] S_WR   = 3'd5;

    localparam logic [7:0] HDR_IMEM = 8'h01;
    localparam logic [7:0] HDR_DMEM = 8'h02;
    localparam logic [7:0] HDR_RUN  = 8'hFF;

    logic [2:0] state;
    logic       target_dmem;
    logic [7:0] count;
    logic       accept;

    assign in_ready = !rst && (state != S_WR);
    assign accept   = in_valid && in_ready;

    // Strobes and pulses default low each cycle; wr_addr doubles as the running address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            target_dmem <= 1'b0;
            count       <= 8'd0;
            imem_we     <= 1'b0;
            dmem_we     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            cpu_hold    <= 1'b1;
            load_done   <= 1'b0;
            err         <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            load_done <= 1'b0;
            err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (in_data == HDR_IMEM || in_data == HDR_DMEM) begin
                            target_dmem <= (in_data == HDR_DMEM);
                            cpu_hold    <= 1'b1;
                            state       <= S_CNT;
                        end else if (in_data == HDR_RUN) begin
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_CNT: begin
                    if (accept) begin
                        count <= in_data;
                        state <= S_ADR;
                    end
                end
                S_ADR: begin
                    if (accept) begin
                        wr_addr <= ADDR_W'(in_data);
                        if (count == 8'd0) begin
                            load_done <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (accept) begin
                        wr_data[DATA_W-1 -: 8] <= in_data;
                        state                  <= S_LO;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        wr_data[7:0] <= in_data;
                        imem_we      <= !target_dmem;
                        dmem_we      <= target_dmem;
                        state        <= S_WR;
                    end
                end
                S_WR: begin
                    // The strobe is high during this cycle; advance for the next word.
                    wr_addr <= wr_addr + ADDR_W'(1);
                    count   <= count - 8'd1;
                    if (count == 8'd1) begin
                        load_done <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        state <= S_HI;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: directed byte streams push expected
// write/load_done/err events; a negedge monitor pops and compares them.
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic        dmem_we;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    localparam int EV_IMEM = 0;
    localparam int EV_DMEM = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];

    program_loader #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .dmem_we   (dmem_we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expectEvent(input int kind, input logic [7:0] addr, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at a negedge with in_valid low after the byte is taken.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int guard;
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic sendStream(input logic [7:0] bytes[$], input int gap);
        foreach (bytes[i]) applyStimulus(bytes[i], gap);
    endtask

    task automatic popCheck(input int kind, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_%s: got event kind %0d expected none at %0t", name, kind, $time);
        end else begin
            e = exp_q.pop_front();
            checkOutput({name, "_kind"}, kind, e.kind);
            if (kind == EV_IMEM || kind == EV_DMEM) begin
                checkOutput({name, "_addr"}, wr_addr, e.addr);
                checkOutput({name, "_data"}, wr_data, e.data);
            end
        end
    endtask

    // Monitor: every observed strobe/pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (imem_we && dmem_we) checkOutput("both_we", 1, 0);
            if (imem_we)   popCheck(EV_IMEM, "imem_write");
            if (dmem_we)   popCheck(EV_DMEM, "dmem_write");
            if (load_done) popCheck(EV_DONE, "load_done");
            if (err)       popCheck(EV_ERR, "err");
            if (!rst) checkOutput("in_ready_vs_wr", in_ready, !(imem_we || dmem_we));
        end
    end

    initial begin
        logic [7:0] s[$];
        int guard;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);

        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_imem_we", imem_we, 0);
        checkOutput("rst_dmem_we", dmem_we, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_cpu_hold", cpu_hold, 1);
        checkOutput("rst_load_done", load_done, 0);
        checkOutput("rst_err", err, 0);

        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", in_ready, 1);
        checkOutput("post_rst_cpu_hold", cpu_hold, 1);
        mon_en = 1'b1;

        $display("[TB] IMEM block of two words");
        expectEvent(EV_IMEM, 8'h10, 16'h1234);
        expectEvent(EV_IMEM, 8'h11, 16'hABCD);
        expectEvent(EV_DONE, 8'h00, 16'h0000);
        s = '{8'h01, 8'h02, 8'h10, 8'h12, 8'h34, 8'hAB, 8'hCD};
        sendStream(s, 0);
        repeat (3) @(negedge clk);
        checkOutput("imem_cpu_hold", cpu_hold, 1);

        $display("[TB] DMEM block wrapping address");
        expectEvent(EV_DMEM, 8'hFF, 16'h0007);
        expectEvent(EV_DMEM, 8'h00, 16'h0008);
        expectEvent(EV_DONE, 8'h00, 16'h0000);
        s = '{8'h02, 8'h02, 8'hFF, 8'h00, 8'h07, 8'h00, 8'h08};
        sendStream(s, 0);
        repeat (3) @(negedge clk);

        $display("[TB] empty block, bad header, run");
        expectEvent(EV_DONE, 8'h00, 16'h0000);
        s = '{8'h01, 8'h00, 8'h20};
        sendStream(s, 0);
        repeat (2) @(negedge clk);
        expectEvent(EV_ERR, 8'h00, 16'h0000);
        applyStimulus(8'h55, 2);
        checkOutput("bad_hdr_cpu_hold", cpu_hold, 1);
        applyStimulus(8'hFF, 1);
        checkOutput("run_cpu_hold", cpu_hold, 0);

        $display("[TB] IMEM block with stalling host");
        expectEvent(EV_IMEM, 8'h30, 16'hDEAD);
        expectEvent(EV_IMEM, 8'h31, 16'hBEEF);
        expectEvent(EV_DONE, 8'h00, 16'h0000);
        s = '{8'h01, 8'h02, 8'h30, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        sendStream(s, 1);
        repeat (3) @(negedge clk);
        checkOutput("reload_cpu_hold", cpu_hold, 1);

        $display("[TB] reset in the middle of a block");
        applyStimulus(8'hFF, 1);
        checkOutput("run2_cpu_hold", cpu_hold, 0);
        s = '{8'h01, 8'h03, 8'h40, 8'h11};
        sendStream(s, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_in_ready", in_ready, 0);
        checkOutput("mid_rst_cpu_hold", cpu_hold, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("after_abort_in_ready", in_ready, 1);
        expectEvent(EV_IMEM, 8'h00, 16'hAABB);
        expectEvent(EV_DONE, 8'h00, 16'h0000);
        s = '{8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB};
        sendStream(s, 0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        checkOutput("pending_events", exp_q.size(), 0);
        checkOutput("final_cpu_hold", cpu_hold, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
